// File: rtl/l1_mem_pkg.sv
// Shared definitions for the L1 side of the compressed line-fill protocol:
// FSM states, line geometry and the idle value of the data-ack index.
package l1_mem_pkg;

    localparam int unsigned LINE_WORDS      = 8;
    localparam logic [3:0]  ACK_IDLE        = 4'b1111;
    localparam logic [2:0]  LAST_IDX        = 3'd7;
    localparam logic [31:0] LINE_ALIGN_MASK = 32'hFFFF_FFF8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        WAIT_CNT,
        WAIT_BASE,
        FINISH,
        DONE
    } fill_state_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & LINE_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/line_run_buffer.sv
// 8x32 line storage with a per-word valid mask; one write fills a run of
// consecutive words with the same value.
module line_run_buffer
    import l1_mem_pkg::*;
(
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic [2:0]                   wr_start,
    input  logic [3:0]                   wr_count,
    input  logic [31:0]                  wr_data,
    output logic [32*LINE_WORDS-1:0]     line,
    output logic [LINE_WORDS-1:0]        valid_mask
);

    logic [LINE_WORDS-1:0] run_mask;

    // Words at or beyond the end of the line simply fall outside the mask.
    always_comb begin
        run_mask = '0;
        for (int unsigned i = 0; i < LINE_WORDS; i++) begin
            run_mask[i] = (i >= 32'(wr_start)) &&
                          (i < 32'(wr_start) + 32'(wr_count));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            line       <= '0;
            valid_mask <= '0;
        end else if (clear) begin
            line       <= '0;
            valid_mask <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < LINE_WORDS; i++) begin
                if (run_mask[i]) begin
                    line[32*i +: 32] <= wr_data;
                end
            end
            valid_mask <= valid_mask | run_mask;
        end
    end

endmodule

// File: rtl/l1_line_fill_unit.sv
// L1-side receiver for compressed line fills: requests a line from memory,
// expands (base, run count) pairs into a line buffer and hands it to the L1.
module l1_line_fill_unit #(
    parameter int unsigned LINE_WORDS     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        req_valid,
    input  logic [31:0]                 req_addr,
    output logic                        req_ready,
    output logic                        fill_valid,
    output logic [31:0]                 fill_addr,
    output logic [32*LINE_WORDS-1:0]    fill_line,
    output logic                        fill_err,
    output logic                        VALID,
    output logic                        LOAD,
    output logic                        STORE,
    input  logic                        READY,
    output logic [31:0]                 DATA_L1,
    input  logic [31:0]                 DATA_MEM,
    output logic                        ACK_ADDR_L1,
    input  logic                        ACK_ADDR_MEM,
    output logic [3:0]                  ACK_DATA_L1,
    input  logic [3:0]                  ACK_DATA_MEM,
    output logic                        ACK_COUNT_L1,
    input  logic                        ACK_COUNT_MEM,
    output logic                        RESET_ACK_L1,
    input  logic                        RESET_ACK_MEM
);

    import l1_mem_pkg::*;

    localparam int unsigned TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    fill_state_t           state;
    logic [TW-1:0]         timer;
    logic [31:0]           line_addr;
    logic [31:0]           base;
    logic [2:0]            idx;
    logic                  run_err;
    logic [LINE_WORDS-1:0] valid_mask;

    logic                  accept;
    logic                  timed_out;
    logic                  buf_wr;
    logic [3:0]            cnt_eff;
    logic [4:0]            run_sum;
    logic [3:0]            run_len;
    logic [2:0]            run_last;
    logic                  cnt_err;

    assign STORE     = 1'b0;
    assign fill_addr = line_addr;
    assign accept    = req_valid && req_ready;
    assign timed_out = (state != IDLE) && (state != DONE) && (timer == TIMEOUT_LAST);
    assign buf_wr    = (state == WAIT_CNT) && ACK_COUNT_MEM && !timed_out;

    // A zero count still consumes one word; runs past word 7 are clipped.
    always_comb begin
        cnt_eff = (DATA_MEM[3:0] == 4'd0) ? 4'd1 : DATA_MEM[3:0];
        run_sum = {2'b00, idx} + {1'b0, cnt_eff};
        cnt_err = (DATA_MEM[3:0] == 4'd0) || (DATA_MEM[31:4] != '0);
        if (run_sum > 5'd8) begin
            run_len  = 4'(5'd8 - {2'b00, idx});
            run_last = LAST_IDX;
            cnt_err  = 1'b1;
        end else begin
            run_len  = cnt_eff;
            run_last = 3'(run_sum - 5'd1);
        end
    end

    line_run_buffer u_buf (
        .CLK        (CLK),
        .RST        (RST),
        .clear      (accept),
        .wr_en      (buf_wr),
        .wr_start   (idx),
        .wr_count   (run_len),
        .wr_data    (base),
        .line       (fill_line),
        .valid_mask (valid_mask)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            timer        <= '0;
            line_addr    <= '0;
            base         <= '0;
            idx          <= '0;
            run_err      <= 1'b0;
            req_ready    <= 1'b0;
            fill_valid   <= 1'b0;
            fill_err     <= 1'b0;
            VALID        <= 1'b0;
            LOAD         <= 1'b0;
            DATA_L1      <= '0;
            ACK_ADDR_L1  <= 1'b0;
            ACK_DATA_L1  <= ACK_IDLE;
            ACK_COUNT_L1 <= 1'b0;
            RESET_ACK_L1 <= 1'b0;
        end else begin
            timer        <= timer + TW'(1);
            fill_valid   <= 1'b0;
            fill_err     <= 1'b0;
            RESET_ACK_L1 <= 1'b0;
            if (timed_out) begin
                state        <= IDLE;
                timer        <= '0;
                req_ready    <= 1'b1;
                fill_err     <= 1'b1;
                RESET_ACK_L1 <= 1'b1;
                VALID        <= 1'b0;
                LOAD         <= 1'b0;
                DATA_L1      <= '0;
                ACK_ADDR_L1  <= 1'b0;
                ACK_DATA_L1  <= ACK_IDLE;
                ACK_COUNT_L1 <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        timer     <= '0;
                        req_ready <= 1'b1;
                        if (accept) begin
                            state     <= REQ;
                            req_ready <= 1'b0;
                            line_addr <= line_align(req_addr);
                            run_err   <= 1'b0;
                            VALID     <= 1'b1;
                            LOAD      <= 1'b1;
                        end
                    end
                    REQ: begin
                        if (READY) begin
                            state       <= ADDR;
                            timer       <= '0;
                            DATA_L1     <= line_addr;
                            ACK_ADDR_L1 <= 1'b1;
                        end
                    end
                    ADDR: begin
                        if (ACK_ADDR_MEM && !ACK_COUNT_MEM && (ACK_DATA_MEM == 4'd0)) begin
                            state        <= WAIT_CNT;
                            timer        <= '0;
                            base         <= DATA_MEM;
                            idx          <= '0;
                            ACK_ADDR_L1  <= 1'b0;
                            ACK_DATA_L1  <= 4'd0;
                            ACK_COUNT_L1 <= 1'b0;
                        end
                    end
                    WAIT_CNT: begin
                        if (ACK_COUNT_MEM) begin
                            state        <= (run_last == LAST_IDX) ? FINISH : WAIT_BASE;
                            timer        <= '0;
                            ACK_DATA_L1  <= {1'b0, run_last};
                            ACK_COUNT_L1 <= 1'b1;
                            if (cnt_err) begin
                                run_err <= 1'b1;
                            end
                        end
                    end
                    WAIT_BASE: begin
                        // Only the base word for the next expected index is taken.
                        if (!ACK_COUNT_MEM && (ACK_DATA_MEM == ACK_DATA_L1 + 4'd1)) begin
                            state        <= WAIT_CNT;
                            timer        <= '0;
                            base         <= DATA_MEM;
                            idx          <= ACK_DATA_MEM[2:0];
                            ACK_DATA_L1  <= ACK_DATA_MEM;
                            ACK_COUNT_L1 <= 1'b0;
                        end
                    end
                    FINISH: begin
                        if (RESET_ACK_MEM || !READY) begin
                            state        <= DONE;
                            timer        <= '0;
                            VALID        <= 1'b0;
                            LOAD         <= 1'b0;
                            DATA_L1      <= '0;
                            ACK_COUNT_L1 <= 1'b0;
                            ACK_DATA_L1  <= ACK_IDLE;
                            RESET_ACK_L1 <= 1'b1;
                            fill_valid   <= 1'b1;
                            fill_err     <= run_err || (valid_mask != '1);
                        end
                    end
                    DONE: begin
                        state     <= IDLE;
                        timer     <= '0;
                        req_ready <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_l1_line_fill_unit.sv
// Directed bench for l1_line_fill_unit: the bench plays main memory and
// checks each handshake and the delivered line against hand-computed values.
module tb_l1_line_fill_unit;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         req_ready;
    logic         fill_valid;
    logic [31:0]  fill_addr;
    logic [255:0] fill_line;
    logic         fill_err;
    logic         VALID;
    logic         LOAD;
    logic         STORE;
    logic         READY;
    logic [31:0]  DATA_L1;
    logic [31:0]  DATA_MEM;
    logic         ACK_ADDR_L1;
    logic         ACK_ADDR_MEM;
    logic [3:0]   ACK_DATA_L1;
    logic [3:0]   ACK_DATA_MEM;
    logic         ACK_COUNT_L1;
    logic         ACK_COUNT_MEM;
    logic         RESET_ACK_L1;
    logic         RESET_ACK_MEM;

    int total = 0;
    int bad   = 0;
    int nfv   = 0;
    int nfv0;
    int n;

    logic [31:0] m_base [8];
    logic [31:0] m_cnt  [8];
    logic [3:0]  m_ack  [16];
    int          m_pairs;

    l1_line_fill_unit #(
        .LINE_WORDS     (8),
        .TIMEOUT_CYCLES (256)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .fill_valid    (fill_valid),
        .fill_addr     (fill_addr),
        .fill_line     (fill_line),
        .fill_err      (fill_err),
        .VALID         (VALID),
        .LOAD          (LOAD),
        .STORE         (STORE),
        .READY         (READY),
        .DATA_L1       (DATA_L1),
        .DATA_MEM      (DATA_MEM),
        .ACK_ADDR_L1   (ACK_ADDR_L1),
        .ACK_ADDR_MEM  (ACK_ADDR_MEM),
        .ACK_DATA_L1   (ACK_DATA_L1),
        .ACK_DATA_MEM  (ACK_DATA_MEM),
        .ACK_COUNT_L1  (ACK_COUNT_L1),
        .ACK_COUNT_MEM (ACK_COUNT_MEM),
        .RESET_ACK_L1  (RESET_ACK_L1),
        .RESET_ACK_MEM (RESET_ACK_MEM)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (fill_valid) nfv++;
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_met(input int sel);
        case (sel)
            0:       return req_ready;
            1:       return ACK_ADDR_L1;
            2:       return !ACK_ADDR_L1 && !ACK_COUNT_L1 && (ACK_DATA_L1 != 4'hF);
            3:       return ACK_COUNT_L1;
            4:       return fill_valid || fill_err;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_cond(input int sel, input string tag);
        int k = 0;
        while (!cond_met(sel) && k < 400) begin
            @(negedge CLK);
            k++;
        end
        chk32({tag, "_wait"}, 32'(k < 400), 32'd1);
    endtask

    task automatic clear_mem;
        READY         = 1'b0;
        DATA_MEM      = '0;
        ACK_ADDR_MEM  = 1'b0;
        ACK_DATA_MEM  = '0;
        ACK_COUNT_MEM = 1'b0;
        RESET_ACK_MEM = 1'b0;
    endtask

    // Memory side of one fill; returns early after pair abort_pair's count.
    task automatic run_fill(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_aligned, input int abort_pair);
        wait_cond(0, {tag, "_ready"});
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge CLK);
        req_valid = 1'b0;
        chk32({tag, "_valid"}, 32'(VALID), 32'd1);
        chk32({tag, "_load"}, 32'(LOAD), 32'd1);
        READY = 1'b1;
        wait_cond(1, {tag, "_ackaddr"});
        chk32({tag, "_data_l1"}, DATA_L1, exp_aligned);
        ACK_ADDR_MEM  = 1'b1;
        ACK_DATA_MEM  = 4'd0;
        ACK_COUNT_MEM = 1'b0;
        DATA_MEM      = m_base[0];
        for (int p = 0; p < m_pairs; p++) begin
            if (p > 0) begin
                ACK_COUNT_MEM = 1'b0;
                ACK_DATA_MEM  = m_ack[2*p-1] + 4'd1;
                DATA_MEM      = m_base[p];
            end
            wait_cond(2, {tag, "_base"});
            chk32({tag, "_ack_base"}, 32'(ACK_DATA_L1), 32'(m_ack[2*p]));
            ACK_ADDR_MEM  = 1'b0;
            ACK_COUNT_MEM = 1'b1;
            DATA_MEM      = m_cnt[p];
            wait_cond(3, {tag, "_cnt"});
            chk32({tag, "_ack_cnt"}, 32'(ACK_DATA_L1), 32'(m_ack[2*p+1]));
            if (p == abort_pair) return;
        end
        READY         = 1'b0;
        RESET_ACK_MEM = 1'b1;
        wait_cond(4, {tag, "_fill"});
    endtask

    task automatic after_fill(input string tag);
        @(negedge CLK);
        clear_mem();
        chk32({tag, "_pulse_end"}, 32'(fill_valid), 32'd0);
        chk32({tag, "_ackdata_idle"}, 32'(ACK_DATA_L1), 32'hF);
    endtask

    initial begin
        req_valid = 1'b0;
        req_addr  = '0;
        clear_mem();

        repeat (3) @(negedge CLK);
        chk32("rst_req_ready", 32'(req_ready), 32'd0);
        chk32("rst_valid", 32'(VALID), 32'd0);
        chk32("rst_ack_data", 32'(ACK_DATA_L1), 32'hF);
        chk32("rst_data_l1", DATA_L1, 32'd0);
        chk32("rst_fill_valid", 32'(fill_valid), 32'd0);
        chk32("rst_store", 32'(STORE), 32'd0);
        chk_line("rst_line", fill_line, 256'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk32("idle_req_ready", 32'(req_ready), 32'd1);

        // Uniform line: one pair covering all eight words.
        m_pairs = 1;
        m_base[0] = 32'h100; m_cnt[0] = 32'd8;
        m_ack[0] = 4'd0; m_ack[1] = 4'd7;
        run_fill("uni", 32'h13, 32'h10, -1);
        chk32("uni_fill_valid", 32'(fill_valid), 32'd1);
        chk32("uni_fill_err", 32'(fill_err), 32'd0);
        chk32("uni_fill_addr", fill_addr, 32'h10);
        chk_line("uni_line", fill_line, {8{32'h100}});
        chk32("uni_reset_ack", 32'(RESET_ACK_L1), 32'd1);
        chk32("uni_valid_drop", 32'(VALID), 32'd0);
        after_fill("uni");

        // Mixed runs.
        m_pairs = 3;
        m_base[0] = 32'h100; m_cnt[0] = 32'd3;
        m_base[1] = 32'h500; m_cnt[1] = 32'd2;
        m_base[2] = 32'h900; m_cnt[2] = 32'd3;
        m_ack[0] = 4'd0; m_ack[1] = 4'd2; m_ack[2] = 4'd3;
        m_ack[3] = 4'd4; m_ack[4] = 4'd5; m_ack[5] = 4'd7;
        run_fill("mix", 32'hABC, 32'hAB8, -1);
        chk32("mix_fill_valid", 32'(fill_valid), 32'd1);
        chk32("mix_fill_err", 32'(fill_err), 32'd0);
        chk32("mix_fill_addr", fill_addr, 32'hAB8);
        chk_line("mix_line", fill_line,
                 {32'h900, 32'h900, 32'h900, 32'h500, 32'h500, 32'h100, 32'h100, 32'h100});
        after_fill("mix");
        repeat (3) @(negedge CLK);
        chk_line("mix_line_held", fill_line,
                 {32'h900, 32'h900, 32'h900, 32'h500, 32'h500, 32'h100, 32'h100, 32'h100});
        chk32("mix_addr_held", fill_addr, 32'hAB8);

        // Eight single-word runs, all distinct.
        m_pairs = 8;
        for (int i = 0; i < 8; i++) begin
            m_base[i]    = 32'hC0DE_0000 + 32'(i);
            m_cnt[i]     = 32'd1;
            m_ack[2*i]   = 4'(i);
            m_ack[2*i+1] = 4'(i);
        end
        nfv0 = nfv;
        run_fill("dst", 32'hFFFF_FFFF, 32'hFFFF_FFF8, -1);
        chk32("dst_fill_err", 32'(fill_err), 32'd0);
        chk32("dst_fill_addr", fill_addr, 32'hFFFF_FFF8);
        chk_line("dst_line", fill_line,
                 {32'hC0DE0007, 32'hC0DE0006, 32'hC0DE0005, 32'hC0DE0004,
                  32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000});
        after_fill("dst");
        repeat (3) @(negedge CLK);
        chk32("dst_pulse_count", 32'(nfv - nfv0), 32'd1);

        // Count 0 then count 9: treated as 1, then clamped at word 7.
        m_pairs = 2;
        m_base[0] = 32'hAAAA_0000; m_cnt[0] = 32'd0;
        m_base[1] = 32'hBBBB_0001; m_cnt[1] = 32'd9;
        m_ack[0] = 4'd0; m_ack[1] = 4'd0; m_ack[2] = 4'd1; m_ack[3] = 4'd7;
        run_fill("clmp", 32'h1237, 32'h1230, -1);
        chk32("clmp_fill_valid", 32'(fill_valid), 32'd1);
        chk32("clmp_fill_err", 32'(fill_err), 32'd1);
        chk_line("clmp_line", fill_line, {{7{32'hBBBB_0001}}, 32'hAAAA_0000});
        after_fill("clmp");

        // Memory stalls in the address phase.
        wait_cond(0, "tmo_ready");
        req_valid = 1'b1;
        req_addr  = 32'h2000_0045;
        @(negedge CLK);
        req_valid = 1'b0;
        READY = 1'b1;
        wait_cond(1, "tmo_ackaddr");
        chk32("tmo_data_l1", DATA_L1, 32'h2000_0040);
        nfv0 = nfv;
        n = 0;
        while (!fill_err && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk32("tmo_cycles", 32'(n), 32'd256);
        chk32("tmo_fill_valid", 32'(fill_valid), 32'd0);
        chk32("tmo_valid", 32'(VALID), 32'd0);
        chk32("tmo_ack_addr", 32'(ACK_ADDR_L1), 32'd0);
        chk32("tmo_reset_ack", 32'(RESET_ACK_L1), 32'd1);
        chk32("tmo_req_ready", 32'(req_ready), 32'd1);
        clear_mem();
        @(negedge CLK);
        chk32("tmo_err_pulse", 32'(fill_err), 32'd0);
        chk32("tmo_no_fill", 32'(nfv - nfv0), 32'd0);

        // Reset while waiting for the second base word.
        m_pairs = 3;
        m_base[0] = 32'h100; m_cnt[0] = 32'd3;
        m_base[1] = 32'h500; m_cnt[1] = 32'd2;
        m_base[2] = 32'h900; m_cnt[2] = 32'd3;
        m_ack[0] = 4'd0; m_ack[1] = 4'd2; m_ack[2] = 4'd3;
        m_ack[3] = 4'd4; m_ack[4] = 4'd5; m_ack[5] = 4'd7;
        nfv0 = nfv;
        run_fill("arst", 32'h50, 32'h50, 0);
        RST = 1'b1;
        #1;
        chk32("arst_valid", 32'(VALID), 32'd0);
        chk32("arst_load", 32'(LOAD), 32'd0);
        chk32("arst_ack_data", 32'(ACK_DATA_L1), 32'hF);
        chk32("arst_ack_cnt", 32'(ACK_COUNT_L1), 32'd0);
        chk32("arst_data_l1", DATA_L1, 32'd0);
        chk32("arst_req_ready", 32'(req_ready), 32'd0);
        chk32("arst_fill_addr", fill_addr, 32'd0);
        chk_line("arst_line", fill_line, 256'd0);
        clear_mem();
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk32("arst_no_fill", 32'(nfv - nfv0), 32'd0);

        m_pairs = 1;
        m_base[0] = 32'h7777; m_cnt[0] = 32'd8;
        m_ack[0] = 4'd0; m_ack[1] = 4'd7;
        run_fill("post", 32'h64, 32'h60, -1);
        chk32("post_fill_valid", 32'(fill_valid), 32'd1);
        chk32("post_fill_err", 32'(fill_err), 32'd0);
        chk32("post_fill_addr", fill_addr, 32'h60);
        chk_line("post_line", fill_line, {8{32'h7777}});
        after_fill("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l1_line_fill_unit.md
Name: l1_line_fill_unit

Overview:
- L1-side receiver for the compressed line-fill protocol of main memory; sits between the L1 cache controller (miss requests) and the main memory block.
- Issues a LOAD, sends the miss address, then collects (base word, run count) pairs. Each pair covers `count` consecutive words, starting at the current index, all approximated by the base word.
- Expands the pairs into an 8-word line buffer and hands the full line to the L1 with its aligned address.

Parameters:
- LINE_WORDS, 8, words per line; fixed at 8 because the index fields are 3 bits.
- TIMEOUT_CYCLES, 256, cycles without memory progress before a fill aborts.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- req_valid  in  1  L1 miss request.
- req_addr  in  32  word address of the miss.
- req_ready  out  1  high in IDLE only; a request is accepted on req_valid && req_ready.
- fill_valid  out  1  one-cycle pulse: line complete.
- fill_addr  out  32  line-aligned address, req_addr with bits [2:0] cleared.
- fill_line  out  256  word i in bits [32i+31:32i].
- fill_err  out  1  one-cycle pulse with fill_valid, or alone on timeout.
- VALID, LOAD  out  1  memory transaction request.
- STORE  out  1  tied 0.
- READY  in  1  memory busy with this transaction.
- DATA_L1  out  32  address to memory.
- DATA_MEM  in  32  base word or count from memory.
- ACK_ADDR_L1  out  1  address valid on DATA_L1.
- ACK_ADDR_MEM  in  1  memory has taken the address.
- ACK_DATA_L1  out  4  index of the last word consumed.
- ACK_DATA_MEM  in  4  index of the base word on DATA_MEM.
- ACK_COUNT_L1  out  1  count consumed.
- ACK_COUNT_MEM  in  1  DATA_MEM holds a count.
- RESET_ACK_L1  out  1  end-of-transaction pulse.
- RESET_ACK_MEM  in  1  memory finished.

Behaviour:
- Reset values: all outputs 0, except ACK_DATA_L1=4'b1111. The line buffer is cleared, idx=0, and the state is IDLE. Reset mid-fill aborts immediately with no fill_valid.
- IDLE:
  - req_ready=1.
  - On accept: latch the aligned address, clear valid_mask[7:0], and go to REQ.
- REQ:
  - VALID=LOAD=1; these stay high until DONE.
  - Wait for READY=1, then go to ADDR.
- ADDR:
  - DATA_L1=aligned address, ACK_ADDR_L1=1.
  - When ACK_ADDR_MEM=1 && ACK_COUNT_MEM=0 && ACK_DATA_MEM=0: capture DATA_MEM as base, idx=0, drop ACK_ADDR_L1, set ACK_DATA_L1=0, ACK_COUNT_L1=0, and go to WAIT_CNT.
- WAIT_CNT:
  - When ACK_COUNT_MEM=1: cnt=DATA_MEM[3:0], and write base into words idx..idx+cnt-1.
  - Set ACK_DATA_L1=idx+cnt-1 and ACK_COUNT_L1=1.
  - If idx+cnt-1 == 7, go to FINISH; otherwise go to WAIT_BASE.
- WAIT_BASE:
  - When ACK_COUNT_MEM=0 && ACK_DATA_MEM == ACK_DATA_L1+1: capture base, idx=ACK_DATA_MEM, set ACK_DATA_L1=idx, ACK_COUNT_L1=0, and go to WAIT_CNT.
  - Stale values where ACK_DATA_MEM != ACK_DATA_L1+1 are ignored.
- FINISH:
  - Hold ACK_DATA_L1=7 and ACK_COUNT_L1=1.
  - Wait for RESET_ACK_MEM=1 or READY=0.
  - Then drop VALID/LOAD and ACK_COUNT_L1, pulse RESET_ACK_L1 for 1 cycle, set ACK_DATA_L1=4'b1111, and go to DONE.
- DONE:
  - fill_valid=1 for one cycle; fill_line/fill_addr are held stable until the next accept.
  - fill_err=1 if any word was never written (valid_mask != 8'hFF).
  - Return to IDLE.
- Count rules:
  - Capture at 32 bits and check that DATA_MEM[31:4]==0.
  - cnt==0 is treated as 1 with the error latched.
  - idx+cnt>8 is clamped so that ACK_DATA_L1=7, writes beyond word 7 are dropped, and the error is latched.
  - The latched error is reported on fill_err at DONE.
- Timeout:
  - A counter resets on every state change. If it reaches TIMEOUT_CYCLES in any state other than IDLE or DONE: pulse fill_err with no fill_valid, drop all memory-side outputs, pulse RESET_ACK_L1, and return to IDLE.
- Latency: minimum 2 cycles per (base, count) pair plus 4 cycles of overhead; the best case (one pair with cnt=8) is about 6 cycles from accept to fill_valid.
- Simultaneous events: req_valid during a fill is not accepted (req_ready=0). An ACK_COUNT_MEM and base-word edge in the same cycle resolves by the current state only.

Decomposition:
- Shared package l1_mem_pkg holds:
  - state enum: IDLE, REQ, ADDR, WAIT_CNT, WAIT_BASE, FINISH, DONE;
  - LINE_WORDS;
  - ACK_IDLE=4'b1111;
  - LAST_IDX=3'd7;
  - the line-alignment mask.
- One sub-module, line_run_buffer, handles the line storage: 8x32 registers plus valid_mask, with a run-write port (start, count, data) and clear.

Test Plan:
- Uniform line, all words 0x100: req_addr=0x13 → DATA_L1=0x10, one pair (0x100, 8), fill_line = 8×0x100, fill_addr=0x10, fill_err=0.
- Mixed runs (0x100,3),(0x500,2),(0x900,3): ACK_DATA_L1 sequence 0,2,3,4,5,7; words 0-2=0x100, 3-4=0x500, 5-7=0x900.
- All-distinct words, 8 pairs of count 1 → line equals memory words exactly; fill_valid exactly once.
- Count 0 then count 9 injected → no hang, words clamped, fill_err=1 with fill_valid.
- Memory stalls after address (READY held, no ACK_ADDR_MEM) → fill_err pulse after 256 cycles, VALID=0, req_ready=1.
- RST asserted in WAIT_BASE → all outputs at reset values in the same cycle, no fill_valid; next request completes normally.
